call_ret_seq: RTL and testbench
===============================

CALL_RET_SEQ -- requirements
Module: call_ret_seq

Interface
REQ-001 Parameter AW, default 10, program-counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 16, number of return-stack entries tracked (matches the attached 16-entry stack).
REQ-003 Reset is reset, synchronous, active-high; clock is clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 en  input  1  op valid this cycle.
REQ-007 op  input  2  operation: 00 SEQ, 01 JUMP, 10 CALL, 11 RET.
REQ-008 target  input  AW  destination for JUMP/CALL.
REQ-009 pc  output  AW  current program counter, registered.
REQ-010 busy  output  1  high while a RET is in flight; ops not accepted.
REQ-011 st_reset  output  1  stack reset, registered copy of reset.
REQ-012 st_push  output  1  stack push strobe, registered, one cycle wide.
REQ-013 st_pop  output  1  stack pop strobe, registered, one cycle wide.
REQ-014 st_inpush  output  AW  value to push (return PC), registered.
REQ-015 st_outpop  input  AW  stack pop data; stack already returns stored value + 1, valid one edge after st_pop sampled.
REQ-016 ovf  output  1  sticky call-overflow flag.
REQ-017 unf  output  1  sticky return-underflow flag.

Function
REQ-018 Op accepted at a rising edge iff en=1, busy=0, reset=0; otherwise pc, depth, flags hold and strobes drop to 0.
REQ-019 FSM states RUN, RET1, RET2; busy=1 in RET1 and RET2 only.
REQ-020 RUN, SEQ: pc <= pc+1, modulo 2^AW (1023 -> 0 at AW=10).
REQ-021 RUN, JUMP: pc <= target; depth unchanged.
REQ-022 RUN, CALL, depth<DEPTH: st_push <= 1, st_inpush <= current pc, pc <= target, depth <= depth+1.
REQ-023 RUN, CALL, depth==DEPTH: no push, ovf <= 1, pc <= pc+1, depth unchanged.
REQ-024 RUN, RET, depth>0: st_pop <= 1, depth <= depth-1, pc holds, next state RET1.
REQ-025 RUN, RET, depth==0: no pop, unf <= 1, pc <= pc+1, stay RUN.
REQ-026 RET1: st_pop <= 0, next state RET2 (stack samples pop at this edge).
REQ-027 RET2: pc <= st_outpop (no further +1 added here), next state RUN; en ignored in RET1/RET2.
REQ-028 RET latency: pc holds the return address 3 edges after RET accepted; a new op is accepted at the 3rd edge at earliest.
REQ-029 depth counter width clog2(DEPTH)+1, range 0..DEPTH, never wraps.
REQ-030 st_push and st_pop never asserted in the same cycle; each strobe is high for exactly one cycle per accepted op.
REQ-031 ovf/unf remain set until reset; they do not block further ops.
REQ-032 Back-to-back CALLs on consecutive cycles each produce a push with their own pc value.

Reset
REQ-033 While reset=1 at an edge: pc <= 0, depth <= 0, state <= RUN, busy/st_push/st_pop/ovf/unf <= 0, st_inpush <= 0, st_reset <= 1.
REQ-034 First edge with reset=0: st_reset <= 0.
REQ-035 Reset in RET1 or RET2 aborts the return: state RUN, pc 0, no pc load from st_outpop.
REQ-036 Reset has priority over every op and FSM transition.

Verification
REQ-037 Reset, then 5 SEQ -> pc 0,1,2,3,4,5; no strobes; flags 0.
REQ-038 pc=5, CALL target=100 -> next edge pc=100, st_push=1 for one cycle with st_inpush=5; then RET -> busy 2 cycles, st_pop=1 one cycle, pc=6 after 3 edges (with real stack model).
REQ-039 16 nested CALLs then a 17th -> 16 pushes, ovf=1, 17th yields pc+1, no push; 16 RETs return in LIFO order, each returning caller pc+1.
REQ-040 After reset, RET -> unf=1, no st_pop, pc=1; unf stays 1 across later ops until reset.
REQ-041 pc=1023, SEQ -> pc=0; CALL at pc=1023 then RET -> pc=0 (stack's +1 wraps).
REQ-042 RET accepted, reset asserted in RET2 -> pc=0, busy=0, st_reset=1, next en op accepted normally.

Source files
------------

// File: rtl/call_ret_seq.sv
// Program-counter sequencer with CALL/RET support driving an external return stack.
// RET is a three-edge sequence: pop strobe, stack read, then pc load from the stack.
module call_ret_seq #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          st_reset,
  output logic          st_push,
  output logic          st_pop,
  output logic [AW-1:0] st_inpush,
  input  logic [AW-1:0] st_outpop,
  output logic          ovf,
  output logic          unf
);
  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] RET1 = 2'd1;
  localparam logic [1:0] RET2 = 2'd2;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  logic [1:0]    state;
  logic [DW-1:0] depth;

  assign busy = (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= '0;
      depth     <= '0;
      st_reset  <= 1'b1;
      st_push   <= 1'b0;
      st_pop    <= 1'b0;
      st_inpush <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      st_reset <= 1'b0;
      st_push  <= 1'b0;
      st_pop   <= 1'b0;
      case (state)
        RUN: begin
          if (en) begin
            case (op)
              OP_SEQ:  pc <= pc + 1'b1;
              OP_JUMP: pc <= target;
              OP_CALL: begin
                if (depth < DEPTH_MAX) begin
                  st_push   <= 1'b1;
                  st_inpush <= pc;
                  pc        <= target;
                  depth     <= depth + 1'b1;
                end else begin
                  ovf <= 1'b1;
                  pc  <= pc + 1'b1;
                end
              end
              OP_RET: begin
                if (depth != '0) begin
                  st_pop <= 1'b1;
                  depth  <= depth - 1'b1;
                  state  <= RET1;
                end else begin
                  unf <= 1'b1;
                  pc  <= pc + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        RET1: state <= RET2;
        // stack already returns caller pc + 1, so load it unmodified
        RET2: begin
          pc    <= st_outpop;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_call_ret_seq.sv
// Directed bench for call_ret_seq with a behavioural 16-entry return stack
// that returns the stored value + 1 one edge after sampling st_pop.
module tb_call_ret_seq;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [1:0]    op;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic          busy, st_reset, st_push, st_pop, ovf, unf;
  logic [AW-1:0] st_inpush;
  logic [AW-1:0] st_outpop;

  int checks = 0;
  int errors = 0;

  call_ret_seq #(.AW(AW), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
    .pc(pc), .busy(busy), .st_reset(st_reset), .st_push(st_push),
    .st_pop(st_pop), .st_inpush(st_inpush), .st_outpop(st_outpop),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // attached stack model
  logic [AW-1:0] smem [16];
  int sp = 0;
  initial st_outpop = '0;
  always @(posedge clk) begin
    if (st_reset) sp <= 0;
    else if (st_push && sp < 16) begin
      smem[sp] <= st_inpush;
      sp <= sp + 1;
    end else if (st_pop && sp > 0) begin
      st_outpop <= smem[sp-1] + 1'b1;
      sp <= sp - 1;
    end
  end

  task automatic step(input logic e, input logic [1:0] o, input logic [AW-1:0] t);
    en = e; op = o; target = t;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 2'b00, '0);
    step(1'b0, 2'b00, '0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    step(1'b1, 2'b10, 10'd33);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc act=%0d exp=0", pc); end
    checks++; if ({busy, st_push, st_pop, ovf, unf} !== 5'b0) begin errors++; $display("FAIL reset_flags act=%b exp=00000", {busy, st_push, st_pop, ovf, unf}); end
    checks++; if (st_inpush !== 10'd0) begin errors++; $display("FAIL reset_inpush act=%0d exp=0", st_inpush); end
    checks++; if (st_reset !== 1'b1) begin errors++; $display("FAIL reset_st_reset act=%b exp=1", st_reset); end
    reset = 1'b0;
    step(1'b0, 2'b00, '0);
    checks++; if (st_reset !== 1'b0) begin errors++; $display("FAIL reset_release act=%b exp=0", st_reset); end
  endtask

  task automatic test_seq();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b00, 10'd999);
      checks++; if (pc !== AW'(i)) begin errors++; $display("FAIL seq_pc act=%0d exp=%0d", pc, i); end
      checks++; if ({st_push, st_pop, ovf, unf} !== 4'b0) begin errors++; $display("FAIL seq_flags act=%b exp=0000", {st_push, st_pop, ovf, unf}); end
    end
  endtask

  task automatic test_call_ret();
    step(1'b1, 2'b10, 10'd100);
    checks++; if (pc !== 10'd100) begin errors++; $display("FAIL call_pc act=%0d exp=100", pc); end
    checks++; if (st_push !== 1'b1 || st_inpush !== 10'd5) begin errors++; $display("FAIL call_push act=%b/%0d exp=1/5", st_push, st_inpush); end
    step(1'b0, 2'b00, '0);
    checks++; if (st_push !== 1'b0) begin errors++; $display("FAIL call_push_width act=%b exp=0", st_push); end
    step(1'b1, 2'b11, '0);
    checks++; if ({busy, st_pop} !== 2'b11 || pc !== 10'd100) begin errors++; $display("FAIL ret_e1 act=%b/%0d exp=11/100", {busy, st_pop}, pc); end
    step(1'b1, 2'b00, '0);
    checks++; if ({busy, st_pop} !== 2'b10 || pc !== 10'd100) begin errors++; $display("FAIL ret_e2 act=%b/%0d exp=10/100", {busy, st_pop}, pc); end
    step(1'b1, 2'b01, 10'd300);
    checks++; if (busy !== 1'b0 || pc !== 10'd6) begin errors++; $display("FAIL ret_e3 act=%b/%0d exp=0/6", busy, pc); end
    step(1'b1, 2'b00, '0);
    checks++; if (pc !== 10'd7) begin errors++; $display("FAIL ret_next_op act=%0d exp=7", pc); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b10, AW'(32 * (i + 1)));
      checks++; if (st_push !== 1'b1 || st_inpush !== AW'(32 * i) || pc !== AW'(32 * (i + 1))) begin
        errors++; $display("FAIL nest_call%0d act=%b/%0d/%0d exp=1/%0d/%0d", i, st_push, st_inpush, pc, 32 * i, 32 * (i + 1)); end
    end
    step(1'b1, 2'b10, 10'd900);
    checks++; if (st_push !== 1'b0 || ovf !== 1'b1 || pc !== 10'd513) begin errors++; $display("FAIL ovf_call act=%b/%b/%0d exp=0/1/513", st_push, ovf, pc); end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'b11, '0);
      step(1'b0, 2'b00, '0);
      step(1'b0, 2'b00, '0);
      checks++; if (pc !== AW'(32 * (15 - k) + 1) || ovf !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL lifo_ret%0d act=%0d/%b exp=%0d/1", k, pc, ovf, 32 * (15 - k) + 1); end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, 2'b11, '0);
    checks++; if (unf !== 1'b1 || st_pop !== 1'b0 || busy !== 1'b0 || pc !== 10'd1) begin errors++; $display("FAIL unf_ret act=%b/%b/%b/%0d exp=1/0/0/1", unf, st_pop, busy, pc); end
    step(1'b1, 2'b00, '0);
    step(1'b1, 2'b01, 10'd50);
    checks++; if (unf !== 1'b1 || pc !== 10'd50) begin errors++; $display("FAIL unf_sticky act=%b/%0d exp=1/50", unf, pc); end
    do_reset();
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clear act=%b exp=0", unf); end
  endtask

  task automatic test_wrap();
    step(1'b1, 2'b01, 10'd1023);
    step(1'b1, 2'b00, '0);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL seq_wrap act=%0d exp=0", pc); end
    step(1'b1, 2'b01, 10'd1023);
    step(1'b1, 2'b10, 10'd7);
    checks++; if (st_inpush !== 10'd1023 || pc !== 10'd7) begin errors++; $display("FAIL wrap_call act=%0d/%0d exp=1023/7", st_inpush, pc); end
    step(1'b1, 2'b11, '0);
    step(1'b0, 2'b00, '0);
    step(1'b0, 2'b00, '0);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL wrap_ret act=%0d exp=0", pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 2'b01, 10'd10);
    step(1'b1, 2'b10, 10'd20);
    checks++; if (st_push !== 1'b1 || st_inpush !== 10'd10) begin errors++; $display("FAIL b2b_call1 act=%b/%0d exp=1/10", st_push, st_inpush); end
    step(1'b1, 2'b10, 10'd30);
    checks++; if (st_push !== 1'b1 || st_inpush !== 10'd20 || pc !== 10'd30) begin errors++; $display("FAIL b2b_call2 act=%b/%0d/%0d exp=1/20/30", st_push, st_inpush, pc); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    step(1'b1, 2'b10, 10'd200);
    step(1'b1, 2'b11, '0);
    step(1'b0, 2'b00, '0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_ret2 act=%b exp=1", busy); end
    reset = 1'b1;
    step(1'b0, 2'b00, '0);
    checks++; if (pc !== 10'd0 || busy !== 1'b0 || st_reset !== 1'b1) begin errors++; $display("FAIL abort_reset act=%0d/%b/%b exp=0/0/1", pc, busy, st_reset); end
    reset = 1'b0;
    step(1'b0, 2'b00, '0);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL abort_no_load act=%0d exp=0", pc); end
    step(1'b1, 2'b00, '0);
    checks++; if (pc !== 10'd1) begin errors++; $display("FAIL abort_next_op act=%0d exp=1", pc); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = 2'b00; target = '0;
    test_reset();
    test_seq();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
